multiplier_ctrl: RTL and testbench

Control FSM for the 8-bit repeated-addition multiplier datapath. It sits directly upstream of `multiplier_DP` and drives its `ldA`, `ldB`, `clrP`, `ldP` and `decB` strobes from the datapath's `eq` flag. It sequences operand capture from the shared `data_in` bus, runs the add/decrement loop until the B counter reaches zero, then holds `done` until the requester acknowledges. A watchdog aborts the loop with an error if `eq` never arrives.

---
 rtl/multiplier_ctrl_if.sv | 42 ++++
 rtl/multiplier_ctrl.sv | 100 ++++++++++
 tb/tb_multiplier_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_ctrl_if.sv
// ============================================================================
// Module   : multiplier_ctrl_if
// Purpose  : Handshake and datapath-strobe bundle between the repeated-addition
//            multiplier controller and its environment (requester + datapath).
// Signals  : start, ack       - requester handshake into the controller
//            eq               - datapath B-counter-is-zero flag
//            opsel            - operand select for the shared data_in bus
//            ldA, ldB, clrP,
//            ldP, decB        - datapath strobes
//            busy, done, err  - controller status
// Modports : master - the controller side
//            slave  - the requester / datapath side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multiplier_ctrl_if;
  logic start;
  logic ack;
  logic eq;
  logic opsel;
  logic ldA;
  logic ldB;
  logic clrP;
  logic ldP;
  logic decB;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, ack, eq,
    output opsel, ldA, ldB, clrP, ldP, decB, busy, done, err
  );

  modport slave (
    output start, ack, eq,
    input  opsel, ldA, ldB, clrP, ldP, decB, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/multiplier_ctrl.sv
// ============================================================================
// Module   : multiplier_ctrl
// Purpose  : Control FSM for an N-bit repeated-addition multiplier datapath.
//            Captures A then B from the shared data_in bus, adds A into P once
//            per B decrement until the datapath reports B == 0, then holds
//            done until acknowledged. A watchdog aborts with err if eq never
//            arrives within 2^N add iterations.
// Ports    : clk     - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            bus     - multiplier_ctrl_if.master (handshake, strobes, status)
// Params   : N       - datapath / B-counter width (watchdog limit 2^N)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_ctrl #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  multiplier_ctrl_if.master  bus
);

  // One-hot state encoding; each output below is a single state flop, so
  // strobes such as clrP come straight off a register and cannot glitch.
  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    LOADA = 6'b000010,
    LOADB = 6'b000100,
    CALC  = 6'b001000,
    DONE  = 6'b010000,
    ERR   = 6'b100000
  } state_t;

  localparam logic [N:0] WD_LIMIT = {1'b1, {N{1'b0}}};

  state_t     state;
  logic [5:0] state_bits;
  logic [N:0] wd_cnt;
  logic       wd_expired;

  assign state_bits = state;
  assign wd_expired = (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= LOADA;
        end
        LOADA: begin
          state <= LOADB;
        end
        LOADB: begin
          state  <= CALC;
          wd_cnt <= '0;
        end
        CALC: begin
          if (bus.eq) begin
            state <= DONE;
          end else if (wd_expired) begin
            state <= ERR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) state <= IDLE;
        end
        ERR: begin
          if (bus.ack) state <= IDLE;
        end
        // Any non-one-hot pattern falls back to IDLE on the next edge.
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // State-flop decodes.
  assign bus.opsel = state_bits[2];
  assign bus.ldA   = state_bits[1];
  assign bus.ldB   = state_bits[2];
  assign bus.clrP  = state_bits[2];
  assign bus.busy  = ~state_bits[0];
  assign bus.done  = state_bits[4] | state_bits[5];
  assign bus.err   = state_bits[5];

  // The only Mealy outputs: an add/decrement happens in CALC while B is
  // nonzero, except on the cycle the watchdog fires.
  assign bus.ldP  = state_bits[3] & ~bus.eq & ~wd_expired;
  assign bus.decB = state_bits[3] & ~bus.eq & ~wd_expired;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_ctrl.sv
// ============================================================================
// Module   : tb_multiplier_ctrl
// Purpose  : Self-checking bench for multiplier_ctrl. A small behavioural
//            datapath (A, B counter, P) is driven by the controller strobes;
//            results are compared with (A*B) mod 256 and with the expected
//            cycle counts derived from B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_ctrl;

  logic clk;
  logic reset_n;
  multiplier_ctrl_if bus ();

  multiplier_ctrl #(.N(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic [7:0] op_a = 8'd0;
  logic [7:0] op_b = 8'd0;
  logic [7:0] a_reg = 8'd0;
  logic [7:0] b_reg = 8'd0;
  logic [7:0] p_reg = 8'd0;
  logic       stub = 1'b0;
  logic [7:0] data_in;

  assign data_in = bus.opsel ? op_b : op_a;
  assign bus.eq  = stub ? 1'b0 : (b_reg == 8'd0);

  always @(posedge clk) begin
    if (bus.ldA) a_reg <= data_in;
    if (bus.ldB) b_reg <= data_in;
    else if (bus.decB) b_reg <= b_reg - 8'd1;
    if (bus.clrP) p_reg <= 8'd0;
    else if (bus.ldP) p_reg <= p_reg + a_reg;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [8:0] all_outs();
    return {bus.opsel, bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB,
            bus.busy, bus.done, bus.err};
  endfunction

  // Starts an operation at the current negedge and runs until done or the
  // budget expires. lat counts edges after the start-sampling edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit start_in_calc, input int budget,
                        output int lat, output int pulses, output bit timeout);
    int dec_pulses;
    op_a = a; op_b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; pulses = 0; dec_pulses = 0; timeout = 1'b0;
    vectors++;
    if ({bus.ldA, bus.opsel, bus.busy, bus.ldB} !== 4'b1010) begin
      miscompares++;
      $display("FAIL loada_strobes: got %b want 1010", {bus.ldA, bus.opsel, bus.busy, bus.ldB});
    end
    @(negedge clk); lat = 1;
    vectors++;
    if ({bus.ldB, bus.clrP, bus.opsel, bus.ldA} !== 4'b1110) begin
      miscompares++;
      $display("FAIL loadb_strobes: got %b want 1110", {bus.ldB, bus.clrP, bus.opsel, bus.ldA});
    end
    @(negedge clk); lat = 2;
    while (bus.done !== 1'b1) begin
      if (lat >= budget) begin
        timeout = 1'b1;
        break;
      end
      if (bus.ldP === 1'b1) pulses++;
      if (bus.decB === 1'b1) dec_pulses++;
      bus.start = (start_in_calc && lat == 3);
      @(negedge clk); lat++;
    end
    bus.start = 1'b0;
    vectors++;
    if (timeout) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles (a=%0d b=%0d)", budget, a, b);
    end
    vectors++;
    if (dec_pulses != pulses) begin
      miscompares++;
      $display("FAIL decb_vs_ldp: decB pulses %0d, ldP pulses %0d", dec_pulses, pulses);
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  // Runs one multiply and compares against the arithmetic model.
  task automatic check_mult(input logic [7:0] a, input logic [7:0] b, input string name);
    int lat, pulses, exp_p;
    bit to;
    exp_p = (int'(a) * int'(b)) % 256;
    run_op(a, b, 1'b0, int'(b) + 20, lat, pulses, to);
    vectors++;
    if (int'(p_reg) != exp_p || lat != 3 + int'(b) || pulses != int'(b) || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: a=%0d b=%0d got P=%0d lat=%0d pulses=%0d err=%b want P=%0d lat=%0d pulses=%0d err=0",
               name, a, b, p_reg, lat, pulses, bus.err, exp_p, 3 + int'(b), b);
    end
    do_ack();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b done=%b want 0 0", name, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (all_outs() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000000", all_outs());
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (all_outs() !== 9'd0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got %b want 000000000", all_outs());
    end
    // Abandon an operation mid-CALC.
    op_a = 8'd50; op_b = 8'd100;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.ldP, bus.done} !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_calc: busy,ldP,done got %b want 110", {bus.busy, bus.ldP, bus.done});
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== 9'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want 000000000", all_outs());
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (all_outs() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 000000000", all_outs());
    end
    check_mult(8'd3, 8'd4, "after_reset");
  endtask

  task automatic test_multiply();
    check_mult(8'd5,   8'd3,   "basic_5x3");
    check_mult(8'd9,   8'd0,   "zero_b");
    check_mult(8'd0,   8'd7,   "zero_a");
    check_mult(8'd20,  8'd20,  "overflow_20x20");
    check_mult(8'd255, 8'd255, "max_255x255");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 40));
      check_mult(a, b, "random");
    end
  endtask

  task automatic test_handshake();
    int lat, pulses;
    bit to;
    run_op(8'd6, 8'd2, 1'b0, 30, lat, pulses, to);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy, bus.err} !== 3'b110) begin
        miscompares++;
        $display("FAIL done_hold: cycle %0d done,busy,err got %b want 110", i, {bus.done, bus.busy, bus.err});
      end
    end
    vectors++;
    if (p_reg !== 8'd12) begin
      miscompares++;
      $display("FAIL hold_result: P got %0d want 12", p_reg);
    end
    // ack and start together: ack wins, no new operation.
    bus.ack = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0; bus.start = 1'b0;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_start_idle: busy,done got %b want 00", {bus.busy, bus.done});
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.ldA} !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_start_no_new_op: busy,ldA got %b want 00", {bus.busy, bus.ldA});
    end
    // start pulsed during CALC is ignored.
    run_op(8'd7, 8'd10, 1'b1, 40, lat, pulses, to);
    vectors++;
    if (p_reg !== 8'd70 || lat != 13 || pulses != 10) begin
      miscompares++;
      $display("FAIL start_in_calc: P=%0d lat=%0d pulses=%0d want 70 13 10", p_reg, lat, pulses);
    end
    do_ack();
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_calc_idle: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    bit to;
    run_op(8'd11, 8'd5, 1'b0, 30, lat, pulses, to);
    vectors++;
    if (p_reg !== 8'd55 || lat != 8) begin
      miscompares++;
      $display("FAIL b2b_first: P=%0d lat=%0d want 55 8", p_reg, lat);
    end
    do_ack();
    run_op(8'd13, 8'd6, 1'b0, 30, lat, pulses, to);
    vectors++;
    if (p_reg !== 8'd78 || lat != 9 || pulses != 6) begin
      miscompares++;
      $display("FAIL b2b_second: P=%0d lat=%0d pulses=%0d want 78 9 6", p_reg, lat, pulses);
    end
    do_ack();
  endtask

  task automatic test_watchdog();
    int lat, pulses;
    bit to;
    stub = 1'b1;
    run_op(8'd3, 8'd5, 1'b0, 400, lat, pulses, to);
    vectors++;
    if (pulses != 256 || lat != 259 || {bus.done, bus.err} !== 2'b11) begin
      miscompares++;
      $display("FAIL watchdog: pulses=%0d lat=%0d done,err=%b want 256 259 11", pulses, lat, {bus.done, bus.err});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.err, bus.ldP, bus.decB} !== 4'b1100) begin
        miscompares++;
        $display("FAIL err_hold: cycle %0d got %b want 1100", i, {bus.done, bus.err, bus.ldP, bus.decB});
      end
    end
    do_ack();
    vectors++;
    if (all_outs() !== 9'd0) begin
      miscompares++;
      $display("FAIL err_ack_idle: got %b want 000000000", all_outs());
    end
    stub = 1'b0;
    check_mult(8'd4, 8'd9, "after_watchdog");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    reset_n   = 1'b0;
    test_reset();
    test_multiply();
    test_random();
    test_handshake();
    test_back_to_back();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
